// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - MULDIV_WIDTH : default operand/result width
//   - OP_*         : op encoding driven by the decoder
//   - muldiv_state_e : control FSM states
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply/divide datapath (combinational).
// Ports:
//   is_div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i     : partial product upper half (mul) / partial remainder (div)
//   quo_i     : multiplier bits still to consume (mul) / dividend shifting into quotient (div)
//   opnd_i    : multiplicand (mul) / divisor (div), both as magnitudes
//   acc_o     : next accumulator
//   quo_o     : next low word
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             unused_diff_bit;

  // The remainder is always below the divisor, so the shifted remainder fits in
  // WIDTH+1 bits; one extra bit on the difference gives the borrow.
  assign mul_sum  = {1'b0, acc_i} + (quo_i[0] ? {1'b0, opnd_i} : '0);
  assign rem_sh   = {acc_i, quo_i[WIDTH-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_i};
  // On a successful subtract the difference is below the divisor, so bit WIDTH is zero.
  assign unused_diff_bit = div_diff[WIDTH];

  always_comb begin
    acc_o = acc_i;
    quo_o = quo_i;
    if (is_div_i) begin
      if (div_diff[WIDTH+1]) begin
        acc_o = rem_sh[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = div_diff[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Add, then shift the carry-extended upper half right into the low word.
      acc_o = mul_sum[WIDTH:1];
      quo_o = {mul_sum[0], quo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. Shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected in a final cycle.
// Ports:
//   clk, startin     : clock, synchronous active-low reset
//   start, op        : issue request and operation (MUL/MULU/DIV/DIVU)
//   src_a, src_b     : multiplicand/dividend, multiplier/divisor
//   flush            : abort the running or issuing operation
//   stall_req        : hold the front of the pipeline
//   busy             : operation in flight (RUN or FIX)
//   done             : one-cycle pulse, hi/lo hold the new result
//   hi, lo           : upper product / remainder, lower product / quotient
//   div_by_zero      : pulse with done for a divide by zero
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             startin,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_out_q, dz_out_d;

  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_acc, step_quo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & src_a[WIDTH-1];
  assign b_neg     = is_signed & src_b[WIDTH-1];
  // abs(MIN) wraps to MIN, which is the correct unsigned magnitude.
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .quo_i    (quo_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .quo_o    (step_quo)
  );

  // Sign correction applied in FIX.
  assign prod     = {acc_q, quo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -quo_q : quo_q;
  // For a zero divisor the remainder is |a|; restoring sign(a) returns src_a exactly.
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;
  assign fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div_q ? (dz_q ? {WIDTH{1'b1}} : quo_fix) : prod_fix[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_out_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d   = StRun;
          cnt_d     = '0;
          acc_d     = '0;
          is_div_d  = op[1];
          opnd_d    = op[1] ? b_mag : a_mag;
          quo_d     = op[1] ? a_mag : b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] & (src_b == '0);
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          hi_d     = fix_hi;
          lo_d     = fix_lo;
          done_d   = 1'b1;
          dz_out_d = dz_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!startin) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_out_q  <= dz_out_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign stall_req   = (start & ~flush & (state_q == StIdle)) | busy;
  assign done        = done_q;
  assign div_by_zero = dz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latency.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         startin = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         stall_req, busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .startin     (startin),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall_req   (stall_req),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from integer arithmetic.
  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l, output bit z);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      OP_MUL:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      OP_MULU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      OP_DIV: begin
        if (b == '0) begin
          z = 1'b1; l = '1; h = a;
        end else begin
          sq = sa / sb; sr = sa % sb;
          l = W'(sq); h = W'(sr);
        end
      end
      default: begin
        if (b == '0) begin
          z = 1'b1; l = '1; h = a;
        end else begin
          uq = ua / ub; ur = ua % ub;
          l = W'(uq); h = W'(ur);
        end
      end
    endcase
  endfunction

  // Model: an accepted operation is outstanding for WIDTH+1 edges, then its
  // result appears for one cycle; flush or reset drop it.
  bit           m_en = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_dz = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;
  bit           p_dz = 1'b0;

  always @(posedge clk) begin
    if (!startin) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
      m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1; m_dz = p_dz; m_hi = p_hi; m_lo = p_lo;
          end
        end
      end else if (start && !flush) begin
        ref_op(op, src_a, src_b, p_hi, p_lo, p_dz);
        m_busy = 1'b1;
        m_left = W + 1;
      end
    end
    m_en = 1'b1;
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("div_by_zero", div_by_zero, m_dz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("stall_req", stall_req, m_busy | (start & ~flush));
    end
  end

  task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic fl);
    @(posedge clk);
    #1;
    start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
  endtask

  // Called in cycle n0 after the issue cycle; waits for done and checks
  // latency and result against literal expectations.
  task automatic wait_done(input int n0, input int lat, input logic [W-1:0] eh,
                           input logic [W-1:0] el, input logic ez, input string name);
    int n = n0;
    bit got = 1'b0;
    while (!got && n < n0 + 200) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check({name, " latency"}, n, lat);
    if (got) begin
      check({name, " hi"}, hi, eh);
      check({name, " lo"}, lo, el);
      check({name, " dz"}, div_by_zero, ez);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                        input string name);
    drive_start(o, a, b, 1'b0);
    drop();
    wait_done(1, W + 2, eh, el, ez, name);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    startin = 1'b1;
    @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    // Largest unsigned product; stall_req raised in the issue cycle itself.
    drive_start(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("issue stall_req", stall_req, 1);
    drop();
    wait_done(1, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "mulu_max");

    // -3 * 7, then -7 / 2 issued in the done cycle.
    drive_start(OP_MUL, 32'hFFFF_FFFD, 32'd7, 1'b0);
    drop();
    repeat (32) @(posedge clk);
    drive_start(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(negedge clk);
    check("mul_neg done", done, 1);
    check("mul_neg hi", hi, 32'hFFFF_FFFF);
    check("mul_neg lo", lo, 32'hFFFF_FFEB);
    check("b2b stall_req", stall_req, 1);
    drop();
    wait_done(1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");

    run_op(OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_min");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
    run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mul_min");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_neg_zero");
    run_op(OP_DIVU, 32'd1000, 32'd7, 32'h6, 32'h8E, 1'b0, "divu_1000_7");
    run_op(OP_MULU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, "mulu_shift");

    // Flush 10 cycles after issue, then a fresh start in the following cycle.
    drive_start(OP_MULU, 32'd5, 32'd6, 1'b0);
    drop();
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b1; op = OP_MULU; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    check("flush hi kept", hi, 32'h1);
    check("flush lo kept", lo, 32'h2345_6780);
    drop();
    wait_done(1, 34, 32'h0, 32'd30, 1'b0, "after_flush");

    // Flush together with start in IDLE: not accepted.
    drive_start(OP_MULU, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    check("flush_start stall_req", stall_req, 0);
    drop();
    @(negedge clk);
    check("flush_start busy", busy, 0);
    repeat (40) @(posedge clk);
    check("flush_start lo kept", lo, 32'd30);

    // A start while busy is ignored.
    drive_start(OP_MULU, 32'd3, 32'd4, 1'b0);
    drop();
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = OP_DIVU; src_a = 32'd99; src_b = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, 34, 32'h0, 32'd12, 1'b0, "start_while_busy");

    // Reset mid-RUN.
    drive_start(OP_MUL, 32'd1234, 32'd5678, 1'b0);
    drop();
    repeat (10) @(posedge clk);
    #1;
    startin = 1'b0;
    @(posedge clk);
    #1;
    startin = 1'b1;
    @(negedge clk);
    check("rst_abort hi", hi, 0);
    check("rst_abort lo", lo, 0);
    check("rst_abort busy", busy, 0);
    check("rst_abort done", done, 0);
    run_op(OP_DIVU, 32'd1000, 32'd7, 32'h6, 32'h8E, 1'b0, "after_reset");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
